hdlc_host_seq: RTL and testbench

HDLC_HOST_SEQ -- requirements
Module: hdlc_host_seq

---
 rtl/hdlc_host_seq.sv | 208 ++++++++++++++++++++
 tb/tb_hdlc_host_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_host_seq.sv
// hdlc_host_seq: host-side sequencer for an HDLC controller register block.
// Polls the RX status register and moves received frames onto the RxOut
// stream, and loads TxIn frames into the TX buffer. RX and TX are served
// round-robin, one whole frame at a time.
// Optional build macro HDLC_HOST_SEQ_TXLEN_CHECK_EN: a TX frame still running
// at its 126th byte is aborted, and its remaining bytes are discarded.
module hdlc_host_seq (
  input  logic       Clk,
  input  logic       Rst,
  output logic [2:0] Bus_Addr,
  output logic       Bus_WrEn,
  output logic       Bus_RdEn,
  output logic [7:0] Bus_WrData,
  input  logic [7:0] Bus_RdData,
  input  logic       TxIn_Valid,
  input  logic [7:0] TxIn_Data,
  input  logic       TxIn_Last,
  output logic       TxIn_Ready,
  output logic       RxOut_Valid,
  output logic [7:0] RxOut_Data,
  output logic       RxOut_Last,
  input  logic       RxOut_Ready,
  input  logic       Cfg_FcsEn,
  output logic       Err_Drop,
  output logic       Busy
);

  localparam logic [2:0] ADDR_TX_SC  = 3'd0;
  localparam logic [2:0] ADDR_TX_BUF = 3'd1;
  localparam logic [2:0] ADDR_RX_SC  = 3'd2;
  localparam logic [2:0] ADDR_RX_BUF = 3'd3;
  localparam logic [2:0] ADDR_RX_LEN = 3'd4;

  typedef enum logic [3:0] {
    INIT, IDLE, POLL_RX, RX_LEN, RX_DATA, RX_DROP,
    POLL_TX, TX_LOAD, TX_START, TX_ABORT, TX_FLUSH
  } state_t;

  state_t     state;
  logic [7:0] rx_cnt;
  logic [6:0] tx_cnt;
  logic       fcs_q;
  logic       grant_rx;   // last frame grant went to RX

  logic       wr_int;
  logic       rd_int;
  logic       rx_rd_fire;
  logic       tx_take;
  logic [6:0] tx_cnt_inc;

  // A buffer read is allowed whenever the output register is free or draining.
  assign rx_rd_fire = (state == RX_DATA) && (!RxOut_Valid || RxOut_Ready);
  assign tx_take    = (state == TX_LOAD) && TxIn_Valid;
  assign tx_cnt_inc = (tx_cnt == 7'd127) ? tx_cnt : tx_cnt + 7'd1;

  assign TxIn_Ready = (state == TX_LOAD) || (state == TX_FLUSH);

  // NOTE: strobes and Busy are gated by Rst so that nothing reaches the
  // register block while reset is held, even though state already reads INIT.
  assign Bus_WrEn = Rst && wr_int;
  assign Bus_RdEn = Rst && rd_int;
  assign Busy     = Rst && (state != IDLE);

  // Bus access decode from state, counters and stream handshakes.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wr_int     = 1'b0;
    rd_int     = 1'b0;
    Bus_Addr   = ADDR_TX_SC;
    Bus_WrData = 8'h00;
    case (state)
      INIT: begin
        wr_int     = 1'b1;
        Bus_Addr   = ADDR_RX_SC;
        Bus_WrData = {2'b00, Cfg_FcsEn, 5'b0};
      end
      POLL_RX: begin
        rd_int   = 1'b1;
        Bus_Addr = ADDR_RX_SC;
      end
      RX_LEN: begin
        rd_int   = 1'b1;
        Bus_Addr = ADDR_RX_LEN;
      end
      RX_DATA: begin
        rd_int   = rx_rd_fire;
        Bus_Addr = ADDR_RX_BUF;
      end
      RX_DROP: begin
        wr_int     = 1'b1;
        Bus_Addr   = ADDR_RX_SC;
        Bus_WrData = {2'b00, fcs_q, 3'b0, 1'b1, 1'b0};
      end
      POLL_TX: begin
        rd_int   = 1'b1;
        Bus_Addr = ADDR_TX_SC;
      end
      TX_LOAD: begin
        wr_int     = tx_take;
        Bus_Addr   = ADDR_TX_BUF;
        Bus_WrData = TxIn_Data;
      end
      TX_START: begin
        wr_int     = 1'b1;
        Bus_Addr   = ADDR_TX_SC;
        Bus_WrData = 8'h02;
      end
      TX_ABORT: begin
        wr_int     = 1'b1;
        Bus_Addr   = ADDR_TX_SC;
        Bus_WrData = 8'h04;
      end
      default: ;
    endcase
  end

  // Sequencer state, counters, RX output register and drop pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= INIT;
      rx_cnt      <= 8'd0;
      tx_cnt      <= 7'd0;
      fcs_q       <= 1'b0;
      grant_rx    <= 1'b0;
      RxOut_Valid <= 1'b0;
      RxOut_Data  <= 8'h00;
      RxOut_Last  <= 1'b0;
      Err_Drop    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block
      // override earlier ones, which is how a same-cycle read keeps Valid set.
      Err_Drop <= 1'b0;
      if (RxOut_Ready) RxOut_Valid <= 1'b0;
      if (rx_rd_fire) begin
        RxOut_Valid <= 1'b1;
        RxOut_Data  <= Bus_RdData;
        RxOut_Last  <= (rx_cnt == 8'd1);
        rx_cnt      <= rx_cnt - 8'd1;
      end

      case (state)
        INIT: begin
          fcs_q <= Cfg_FcsEn;
          state <= IDLE;
        end
        IDLE: begin
          if (Cfg_FcsEn != fcs_q)        state <= INIT;
          else if (TxIn_Valid && grant_rx) state <= POLL_TX;
          else                           state <= POLL_RX;
        end
        POLL_RX: begin
          if (Bus_RdData[0] && (|Bus_RdData[4:2])) state <= RX_DROP;
          else if (Bus_RdData[0])                  state <= RX_LEN;
          else if (TxIn_Valid)                     state <= POLL_TX;
          else                                     state <= IDLE;
        end
        RX_LEN: begin
          rx_cnt <= Bus_RdData;
          state  <= (Bus_RdData == 8'd0) ? RX_DROP : RX_DATA;
        end
        RX_DATA: begin
          if (rx_rd_fire && (rx_cnt == 8'd1)) begin
            state    <= IDLE;
            grant_rx <= 1'b1;
          end
        end
        RX_DROP: begin
          Err_Drop <= 1'b1;
          grant_rx <= 1'b1;
          state    <= IDLE;
        end
        POLL_TX: begin
          if (Bus_RdData[0] && !Bus_RdData[4]) begin
            tx_cnt <= 7'd0;
            state  <= TX_LOAD;
          end else begin
            grant_rx <= 1'b0;
            state    <= IDLE;
          end
        end
        TX_LOAD: begin
          if (tx_take) begin
            tx_cnt <= tx_cnt_inc;
            if (TxIn_Last) state <= TX_START;
`ifdef HDLC_HOST_SEQ_TXLEN_CHECK_EN
            else if (tx_cnt == 7'd125) state <= TX_ABORT;
`endif
          end
        end
        TX_START: begin
          grant_rx <= 1'b0;
          state    <= IDLE;
        end
        TX_ABORT: begin
          state <= TX_FLUSH;
        end
        TX_FLUSH: begin
          if (TxIn_Valid && TxIn_Last) begin
            grant_rx <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_host_seq.sv
// tb_hdlc_host_seq: directed bench for hdlc_host_seq with a small HDLC
// register-block model, a bus monitor and a table of RX status responses.
module tb_hdlc_host_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] Bus_Addr;
  logic       Bus_WrEn, Bus_RdEn;
  logic [7:0] Bus_WrData, Bus_RdData;
  logic       TxIn_Valid, TxIn_Last, TxIn_Ready;
  logic [7:0] TxIn_Data;
  logic       RxOut_Valid, RxOut_Last, RxOut_Ready;
  logic [7:0] RxOut_Data;
  logic       Cfg_FcsEn, Err_Drop, Busy;

  hdlc_host_seq dut (
    .Clk(Clk), .Rst(Rst),
    .Bus_Addr(Bus_Addr), .Bus_WrEn(Bus_WrEn), .Bus_RdEn(Bus_RdEn),
    .Bus_WrData(Bus_WrData), .Bus_RdData(Bus_RdData),
    .TxIn_Valid(TxIn_Valid), .TxIn_Data(TxIn_Data), .TxIn_Last(TxIn_Last),
    .TxIn_Ready(TxIn_Ready),
    .RxOut_Valid(RxOut_Valid), .RxOut_Data(RxOut_Data), .RxOut_Last(RxOut_Last),
    .RxOut_Ready(RxOut_Ready),
    .Cfg_FcsEn(Cfg_FcsEn), .Err_Drop(Err_Drop), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // ---------------- register block model ----------------
  logic [7:0] rx_sc_cfg = 8'h00;
  logic [7:0] rx_len_cfg = 8'h00;
  logic [7:0] tx_sc_cfg = 8'h01;
  logic [7:0] rx_buf [4];
  int         rx_req = 0;     // frames offered by the test
  int         rx_done = 0;    // frames consumed by the model
  logic [1:0] rx_idx = 2'd0;
  logic       pending;

  assign pending = (rx_req != rx_done);

  always_comb begin
    case (Bus_Addr)
      3'd0:    Bus_RdData = tx_sc_cfg;
      3'd2:    Bus_RdData = pending ? rx_sc_cfg : 8'h00;
      3'd3:    Bus_RdData = rx_buf[rx_idx];
      3'd4:    Bus_RdData = rx_len_cfg;
      default: Bus_RdData = 8'h00;
    endcase
  end

  // A status read of a non-ready frame, a length read or a drop write retires it.
  always @(posedge Clk) begin
    if (Bus_RdEn && Bus_Addr == 3'd4 && pending) begin
      rx_done <= rx_done + 1;
      rx_idx  <= 2'd0;
    end else if (Bus_RdEn && Bus_Addr == 3'd3) begin
      rx_idx <= rx_idx + 2'd1;
    end
    if (Bus_RdEn && Bus_Addr == 3'd2 && pending && !rx_sc_cfg[0]) rx_done <= rx_done + 1;
    if (Bus_WrEn && Bus_Addr == 3'd2 && Bus_WrData[1] && pending) rx_done <= rx_done + 1;
  end

  // ---------------- bus / stream monitor ----------------
  int         cyc = 0;
  int         n_rd2 = 0, n_rd3 = 0, n_dropwr = 0, n_err_drop = 0;
  int         excl_err = 0, rst_acc = 0;
  int         wr0_cyc = 0;
  logic [7:0] last_wr0 = 8'hFF, last_wr2 = 8'hFF;
  int         rd3_cyc[$];
  int         wr1_cyc[$];
  logic [7:0] wr1_q[$];
  logic [8:0] xfer_q[$];

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (Bus_WrEn && Bus_RdEn) excl_err <= excl_err + 1;
    if (!Rst && (Bus_WrEn || Bus_RdEn)) rst_acc <= rst_acc + 1;
    if (Err_Drop) n_err_drop <= n_err_drop + 1;
    if (RxOut_Valid && RxOut_Ready) xfer_q.push_back({RxOut_Last, RxOut_Data});
    if (Bus_RdEn && Bus_Addr == 3'd2) n_rd2 <= n_rd2 + 1;
    if (Bus_RdEn && Bus_Addr == 3'd3) begin
      n_rd3 <= n_rd3 + 1;
      rd3_cyc.push_back(cyc);
    end
    if (Bus_WrEn) begin
      case (Bus_Addr)
        3'd0: begin last_wr0 <= Bus_WrData; wr0_cyc <= cyc; end
        3'd1: begin wr1_q.push_back(Bus_WrData); wr1_cyc.push_back(cyc); end
        3'd2: begin
          last_wr2 <= Bus_WrData;
          if (Bus_WrData[1]) n_dropwr <= n_dropwr + 1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic int xfer_at(input int i);
    return (i < xfer_q.size()) ? int'(xfer_q[i]) : -1;
  endfunction
  function automatic int wr1_at(input int i);
    return (i < wr1_q.size()) ? int'(wr1_q[i]) : -1;
  endfunction
  function automatic int wr1c_at(input int i);
    return (i >= 0 && i < wr1_cyc.size()) ? wr1_cyc[i] : -1000;
  endfunction
  function automatic int rd3c_at(input int i);
    return (i >= 0 && i < rd3_cyc.size()) ? rd3_cyc[i] : -1000;
  endfunction
  function automatic logic [7:0] tx_byte(input int i);
    return 8'((i + 1) * 17);
  endfunction

  // Offer bytes 0..n_send-1 of a total-byte frame; optional mid-frame stall
  // that also makes an RX frame pending. Counts RX status reads in the frame.
  task automatic send_frame(input int n_send, input int total, input int stall_at,
                            output int acc, output int rd2_during);
    int   guard;
    int   r_first;
    logic took;
    acc = 0; guard = 0; r_first = n_rd2; rd2_during = 0;
    TxIn_Data  = tx_byte(0);
    TxIn_Last  = (total == 1);
    TxIn_Valid = 1'b1;
    while (acc < n_send && guard < 400) begin
      @(negedge Clk);
      took = TxIn_Valid && TxIn_Ready;
      step(1);
      guard++;
      if (took) begin
        if (acc == 0) r_first = n_rd2;
        acc++;
        rd2_during = n_rd2 - r_first;
        if (stall_at > 0 && acc == stall_at) begin
          TxIn_Valid = 1'b0;
          rx_sc_cfg  = 8'h01;
          rx_len_cfg = 8'd1;
          rx_req++;
          step(3);
          TxIn_Valid = 1'b1;
        end
        TxIn_Data = tx_byte(acc);
        TxIn_Last = (acc == total - 1);
      end
    end
    TxIn_Valid = 1'b0;
    TxIn_Last  = 1'b0;
    check("tx_frame_timeout", int'(guard < 400), 1);
  endtask

  // ---------------- RX status table ----------------
  typedef struct {
    logic [7:0] sc;
    logic [7:0] len;
    int         exp_rd3;
    int         exp_xfer;
    int         exp_drop;
  } rx_vec_t;

  rx_vec_t rx_tab [8];

  initial begin
    int b_rd3, b_x, b_dw, b_ed, b_wr1, b_rd2, acc, rdd, r0, rd_base;

    rx_tab[0] = '{8'h01, 8'd3, 3, 3, 0};   // clean frame
    rx_tab[1] = '{8'h05, 8'd3, 0, 0, 1};   // FrameErr
    rx_tab[2] = '{8'h09, 8'd3, 0, 0, 1};   // Aborted
    rx_tab[3] = '{8'h11, 8'd3, 0, 0, 1};   // Overflow
    rx_tab[4] = '{8'h01, 8'd0, 0, 0, 1};   // zero length
    rx_tab[5] = '{8'h00, 8'd3, 0, 0, 0};   // nothing ready
    rx_tab[6] = '{8'h04, 8'd3, 0, 0, 0};   // error bit without Ready
    rx_tab[7] = '{8'h01, 8'd1, 1, 1, 0};   // single byte

    rx_buf[0] = 8'hA1; rx_buf[1] = 8'hB2; rx_buf[2] = 8'hC3; rx_buf[3] = 8'hD4;
    Rst = 1'b0; Cfg_FcsEn = 1'b1; RxOut_Ready = 1'b1;
    TxIn_Valid = 1'b0; TxIn_Data = 8'h00; TxIn_Last = 1'b0;

    // Reset state
    step(3);
    @(negedge Clk);
    check("rst_busy", int'(Busy), 0);
    check("rst_txready", int'(TxIn_Ready), 0);
    check("rst_rxvalid", int'(RxOut_Valid), 0);
    check("rst_errdrop", int'(Err_Drop), 0);
    check("rst_bus", int'({Bus_WrEn, Bus_RdEn}), 0);

    // First access after release: INIT write with FCS enabled
    step(1);
    Rst = 1'b1;
    @(negedge Clk);
    check("init_wren", int'(Bus_WrEn), 1);
    check("init_addr", int'(Bus_Addr), 2);
    check("init_data", int'(Bus_WrData), 8'h20);
    check("init_busy", int'(Busy), 1);

    // Changing Cfg_FcsEn re-runs INIT
    step(1);
    Cfg_FcsEn = 1'b0;
    step(6);
    check("reinit_data", int'(last_wr2), 8'h00);

    // Clean 3-byte frame, no back-pressure
    b_rd3 = n_rd3; b_x = xfer_q.size();
    rx_sc_cfg = 8'h01; rx_len_cfg = 8'd3; rx_req++;
    step(15);
    check("rx3_reads", n_rd3 - b_rd3, 3);
    check("rx3_consec", rd3c_at(b_rd3 + 2) - rd3c_at(b_rd3), 2);
    check("rx3_b0", xfer_at(b_x), 9'h0A1);
    check("rx3_b1", xfer_at(b_x + 1), 9'h0B2);
    check("rx3_b2", xfer_at(b_x + 2), 9'h1C3);

    // Same frame with a 4-cycle stall after the first byte
    RxOut_Ready = 1'b0;
    b_rd3 = n_rd3; b_x = xfer_q.size();
    rx_req++;
    acc = 0;
    while (!RxOut_Valid && acc < 20) begin step(1); acc++; end
    check("bp_first_valid", int'(RxOut_Valid), 1);
    r0 = n_rd3;
    step(4);
    check("bp_no_reads", n_rd3 - r0, 0);
    check("bp_hold_data", int'(RxOut_Data), 8'hA1);
    RxOut_Ready = 1'b1;
    step(12);
    check("bp_reads", n_rd3 - b_rd3, 3);
    check("bp_xfers", xfer_q.size() - b_x, 3);
    check("bp_b0", xfer_at(b_x), 9'h0A1);
    check("bp_b1", xfer_at(b_x + 1), 9'h0B2);
    check("bp_b2", xfer_at(b_x + 2), 9'h1C3);

    // Table of RX status responses
    for (int v = 0; v < 8; v++) begin
      b_rd3 = n_rd3; b_x = xfer_q.size(); b_dw = n_dropwr; b_ed = n_err_drop;
      rx_sc_cfg = rx_tab[v].sc; rx_len_cfg = rx_tab[v].len; rx_req++;
      step(20);
      check($sformatf("v%0d_reads", v), n_rd3 - b_rd3, rx_tab[v].exp_rd3);
      check($sformatf("v%0d_xfers", v), xfer_q.size() - b_x, rx_tab[v].exp_xfer);
      check($sformatf("v%0d_dropwr", v), n_dropwr - b_dw, rx_tab[v].exp_drop);
      check($sformatf("v%0d_errpulse", v), n_err_drop - b_ed, rx_tab[v].exp_drop);
      if (rx_tab[v].exp_drop == 1) check($sformatf("v%0d_dropdata", v), int'(last_wr2), 8'h02);
    end
    rx_sc_cfg = 8'h00;

    // 4-byte TX frame
    b_wr1 = wr1_q.size();
    send_frame(4, 4, 0, acc, rdd);
    step(4);
    check("tx4_writes", wr1_q.size() - b_wr1, 4);
    check("tx4_d0", wr1_at(b_wr1), 8'h11);
    check("tx4_d1", wr1_at(b_wr1 + 1), 8'h22);
    check("tx4_d2", wr1_at(b_wr1 + 2), 8'h33);
    check("tx4_d3", wr1_at(b_wr1 + 3), 8'h44);
    check("tx4_consec", wr1c_at(b_wr1 + 3) - wr1c_at(b_wr1), 3);
    check("tx4_start_next", wr0_cyc - wr1c_at(b_wr1 + 3), 1);
    check("tx4_start_data", int'(last_wr0), 8'h02);

    // TX frame with a stall while RX becomes pending: no RX service mid-frame
    b_rd3 = n_rd3;
    send_frame(3, 3, 1, acc, rdd);
    step(12);
    check("txrx_no_poll", rdd, 0);
    check("txrx_rx_after", n_rd3 - b_rd3, 1);

    // Exactly 126 bytes ending with Last: normal start
    b_wr1 = wr1_q.size();
    send_frame(126, 126, 0, acc, rdd);
    step(4);
    check("tx126_writes", wr1_q.size() - b_wr1, 126);
    check("tx126_start", int'(last_wr0), 8'h02);

    // 130-byte frame
    b_wr1 = wr1_q.size();
    send_frame(130, 130, 0, acc, rdd);
    step(4);
    check("tx130_accepted", acc, 130);
    check("tx130_ctl_next", wr0_cyc - wr1c_at(wr1_cyc.size() - 1), 1);
`ifdef HDLC_HOST_SEQ_TXLEN_CHECK_EN
    check("tx130_writes", wr1_q.size() - b_wr1, 126);
    check("tx130_abort", int'(last_wr0), 8'h04);
`else
    check("tx130_writes", wr1_q.size() - b_wr1, 130);
    check("tx130_start", int'(last_wr0), 8'h02);
`endif
    rd_base = n_rd2;
    step(6);
    check("tx130_back_idle", int'(n_rd2 > rd_base), 1);

    // Reset in the middle of a TX frame
    send_frame(2, 4, 0, acc, rdd);
    Rst = 1'b0;
    #1;
    check("midrst_txready", int'(TxIn_Ready), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_bus", int'({Bus_WrEn, Bus_RdEn}), 0);
    check("midrst_errdrop", int'(Err_Drop), 0);
    step(2);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_init_wr", int'({Bus_WrEn, Bus_Addr, Bus_WrData}), {1'b1, 3'd2, 8'h00});
    step(4);

    check("rd_wr_exclusive", excl_err, 0);
    check("no_access_in_reset", rst_acc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
